game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter DIV_S0, default 50000000, tick period in clk cycles at speed 0 (1 Hz at 50 MHz).
REQ-002 Parameter DIV_S1, default 12500000, tick period at speed 1.
REQ-003 Parameter DIV_S2, default 5000000, tick period at speed 2.
REQ-004 Parameter DIV_IDLE, default 5000000, tick period in IDLE (attract animation).
REQ-005 clk  input  1  system clock; one clock domain only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start_p  input  1  one-cycle debounced start pulse (centre button).
REQ-008 speed_up_p  input  1  one-cycle debounced speed-increase pulse.
REQ-009 speed_down_p  input  1  one-cycle debounced speed-decrease pulse.
REQ-010 lose_in  input  1  level from the game datapath: player has left the cliff.
REQ-011 state  output  2  00 IDLE, 01 RUN, 10 LOSE; 11 never driven.
REQ-012 speed  output  2  current speed level, 0..2.
REQ-013 tick  output  1  one-cycle game-step enable for the datapath.
REQ-014 clear_field  output  1  one-cycle pulse: datapath reloads starting position.
REQ-015 score  output  14  survived RUN ticks, binary, 0..9999, for the 7-segment display.

Function
REQ-016 Divider: 26-bit counter; tick=1 for exactly one cycle when counter >= active divisor-1; the counter then returns to 0, otherwise it increments.
REQ-017 Active divisor: DIV_IDLE in IDLE; DIV_S0/S1/S2 selected by speed in RUN; in LOSE the counter holds at 0 and tick=0.
REQ-018 The comparison uses >=, so lowering the divisor mid-count produces a tick on the next cycle, never a missed wrap.
REQ-019 IDLE->RUN on start_p: clear_field=1 that same cycle, counter=0, score=0; first RUN tick DIV_Sx cycles after the entry cycle.
REQ-020 RUN->LOSE when lose_in=1 is sampled; tick is suppressed in the transition cycle; score freezes.
REQ-021 LOSE->IDLE on start_p; speed and score are retained until the next IDLE->RUN.
REQ-022 In RUN, start_p is ignored; if start_p and lose_in coincide in RUN, LOSE wins.
REQ-023 In IDLE, lose_in is ignored.
REQ-024 speed_up_p increments speed, saturating at 2; speed_down_p decrements it, saturating at 0; both are accepted in IDLE and RUN and ignored in LOSE.
REQ-025 speed_up_p and speed_down_p together in the same cycle: speed unchanged.
REQ-026 score increments by 1 on each RUN tick and saturates at 9999.
REQ-027 All outputs are registered; tick and clear_field are never high for two consecutive cycles.

Reset
REQ-028 reset has priority over all inputs: state=IDLE, speed=0, counter=0, score=0, tick=0, clear_field=0 on the next edge.
REQ-029 reset during RUN or LOSE aborts immediately; clear_field is not pulsed by reset (the datapath has its own reset).

Configuration
REQ-030 Macro AUTO_SPEEDUP_EN. Defined: in RUN, every 16th tick (score[3:0] wrapping to 0 after the increment) increments speed, saturating at 2. If a manual pulse coincides with it, the manual pulse wins.
REQ-031 Undefined: speed changes only via speed_up_p/speed_down_p; no extra logic is synthesised.

Verification (DIV_S0=8, DIV_S1=4, DIV_S2=2, DIV_IDLE=2)
REQ-032 Reset, then idle 10 cycles -> state=00, tick every 2nd cycle, score=0, speed=0.
REQ-033 start_p in IDLE -> clear_field one cycle, state=01, tick at +8, +16, +24 cycles, score=3 after the third tick.
REQ-034 speed_up_p x3 in RUN -> speed 1, 2, 2; tick period 2; speed_up_p and speed_down_p together -> speed unchanged.
REQ-035 lose_in=1 together with start_p in RUN -> state=10 next cycle, no tick, score frozen; later start_p -> state=00.
REQ-036 reset asserted mid-RUN at score=5 -> all outputs at reset values next cycle, no clear_field pulse.
REQ-037 With AUTO_SPEEDUP_EN and speed=0 -> speed=1 after RUN tick 16 and speed=2 after tick 32; without the macro -> speed=0 throughout.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer
// -----------------------------------------------------------------------------
// Purpose: top-level sequencer for the cliff game. It owns the IDLE/RUN/LOSE
// state machine, the speed level, the game-step tick divider and the score.
//
// Ports:
//   clk           system clock (single clock domain)
//   reset         synchronous, active-high reset
//   start_p       one-cycle start pulse (IDLE->RUN, LOSE->IDLE)
//   speed_up_p    one-cycle speed increase pulse (saturates at 2)
//   speed_down_p  one-cycle speed decrease pulse (saturates at 0)
//   lose_in       level from the datapath: player has left the cliff
//   state         00 IDLE, 01 RUN, 10 LOSE
//   speed         current speed level 0..2
//   tick          one-cycle game-step enable
//   clear_field   one-cycle pulse telling the datapath to reload its start
//   score         survived RUN ticks, binary 0..9999
//
// Configuration macro: AUTO_SPEEDUP_EN
//   When defined, every 16th RUN tick raises the speed by one level
//   (saturating at 2); a manual speed pulse in the same cycle takes priority.
//
// All divisors must be at least 2 so the divider can never fire on two
// consecutive cycles.
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int DIV_S0   = 50000000,
  parameter int DIV_S1   = 12500000,
  parameter int DIV_S2   = 5000000,
  parameter int DIV_IDLE = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_p,
  input  logic        speed_up_p,
  input  logic        speed_down_p,
  input  logic        lose_in,
  output logic [1:0]  state,
  output logic [1:0]  speed,
  output logic        tick,
  output logic        clear_field,
  output logic [13:0] score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOSE = 2'b10
  } state_t;

  localparam logic [25:0] LIM_S0   = 26'(DIV_S0 - 1);
  localparam logic [25:0] LIM_S1   = 26'(DIV_S1 - 1);
  localparam logic [25:0] LIM_S2   = 26'(DIV_S2 - 1);
  localparam logic [25:0] LIM_IDLE = 26'(DIV_IDLE - 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  state_t      cur_state;
  logic [25:0] counter;
  logic [25:0] active_limit;
  logic        div_hit;
  logic [13:0] score_inc;
  logic [1:0]  speed_manual;
  logic [1:0]  speed_next;

  assign state = cur_state;

  // Select the terminal count for the current mode. LOSE never uses the
  // divider, so its value here is irrelevant.
  always_comb begin
    active_limit = LIM_IDLE;
    if (cur_state == ST_RUN) begin
      case (speed)
        2'd0:    active_limit = LIM_S0;
        2'd1:    active_limit = LIM_S1;
        default: active_limit = LIM_S2;
      endcase
    end
  end

  // The >= compare means a divisor lowered mid-count fires on the next cycle
  // instead of wrapping through 2^26. The !tick term keeps ticks apart even if
  // a divisor of 1 were ever configured.
  assign div_hit   = (counter >= active_limit) && !tick;
  assign score_inc = (score == SCORE_MAX) ? score : score + 14'd1;

  // Manual speed request; both pulses together cancel out.
  always_comb begin
    speed_manual = speed;
    if (speed_up_p && !speed_down_p && speed != 2'd2)
      speed_manual = speed + 2'd1;
    else if (speed_down_p && !speed_up_p && speed != 2'd0)
      speed_manual = speed - 2'd1;
  end

`ifdef AUTO_SPEEDUP_EN
  logic auto_bump;

  // A RUN tick whose increment wraps the low score nibble to 0 bumps the speed,
  // unless a manual pulse is present this cycle.
  assign auto_bump = (cur_state == ST_RUN) && !lose_in && div_hit &&
                     (score != SCORE_MAX) && (score_inc[3:0] == 4'd0);

  always_comb begin
    speed_next = speed_manual;
    if (!speed_up_p && !speed_down_p && auto_bump && speed != 2'd2)
      speed_next = speed + 2'd1;
  end
`else
  assign speed_next = speed_manual;
`endif

  // Main sequencer: state, divider, speed, score and the one-cycle pulses are
  // all registered here so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= ST_IDLE;
      speed       <= 2'd0;
      counter     <= 26'd0;
      score       <= 14'd0;
      tick        <= 1'b0;
      clear_field <= 1'b0;
    end else begin
      tick        <= 1'b0;
      clear_field <= 1'b0;

      if (cur_state != ST_LOSE)
        speed <= speed_next;

      case (cur_state)
        ST_IDLE: begin
          if (start_p) begin
            cur_state   <= ST_RUN;
            clear_field <= 1'b1;
            counter     <= 26'd0;
            score       <= 14'd0;
          end else if (div_hit) begin
            tick    <= 1'b1;
            counter <= 26'd0;
          end else begin
            counter <= counter + 26'd1;
          end
        end

        ST_RUN: begin
          // lose_in wins over both start_p and a pending tick.
          if (lose_in) begin
            cur_state <= ST_LOSE;
            counter   <= 26'd0;
          end else if (div_hit) begin
            tick    <= 1'b1;
            counter <= 26'd0;
            score   <= score_inc;
          end else begin
            counter <= counter + 26'd1;
          end
        end

        ST_LOSE: begin
          counter <= 26'd0;
          if (start_p)
            cur_state <= ST_IDLE;
        end

        default: begin
          cur_state <= ST_IDLE;
          counter   <= 26'd0;
        end
      endcase
    end
  end

endmodule
